// File: rtl/axi4_lite_reg_slave_pkg.sv
// Shared types and helpers for the AXI4-Lite register responder.
// Covers response codes, write/read state encodings and register-index decode.
package axi4_lite_reg_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Byte offset bits are dropped, so unaligned addresses hit the containing word;
  // the modulo makes addresses beyond the array alias back onto it.
  function automatic int unsigned reg_index(input logic [31:0] addr,
                                            input int unsigned n_bytes,
                                            input int unsigned depth);
    return (addr / n_bytes) % depth;
  endfunction

endpackage

// File: rtl/axi4_lite_wr_join.sv
// Joins the AW and W handshakes in either order into one commit pulse.
// Owns the write-channel state, awready/wready and bvalid.
module axi4_lite_wr_join
  import axi4_lite_reg_slave_pkg::*;
#(
  parameter int A = 8,
  parameter int N = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [A-1:0]     awaddr,
  input  logic             awvalid,
  output logic             awready,
  input  logic [8*N-1:0]   wdata,
  input  logic [N-1:0]     wstrb,
  input  logic             wvalid,
  output logic             wready,
  output logic             bvalid,
  input  logic             bready,
  output logic             commit,
  output logic [A-1:0]     commit_addr,
  output logic [8*N-1:0]   commit_data,
  output logic [N-1:0]     commit_strb
);

  wr_state_e        state_q, state_d;
  logic [A-1:0]     aw_addr_q, aw_addr_d;
  logic [8*N-1:0]   w_data_q, w_data_d;
  logic [N-1:0]     w_strb_q, w_strb_d;
  logic             awready_q, awready_d;
  logic             wready_q, wready_d;
  logic             bvalid_q, bvalid_d;
  logic             aw_hs;
  logic             w_hs;

  assign aw_hs = awvalid && awready_q;
  assign w_hs  = wvalid && wready_q;

  always_comb begin
    state_d     = state_q;
    aw_addr_d   = aw_addr_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    commit      = 1'b0;
    commit_addr = aw_addr_q;
    commit_data = w_data_q;
    commit_strb = w_strb_q;

    case (state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit      = 1'b1;
          commit_addr = awaddr;
          commit_data = wdata;
          commit_strb = wstrb;
          state_d     = W_RESP;
        end else if (aw_hs) begin
          aw_addr_d = awaddr;
          state_d   = W_HAVE_AW;
        end else if (w_hs) begin
          w_data_d = wdata;
          w_strb_d = wstrb;
          state_d  = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          commit      = 1'b1;
          commit_addr = aw_addr_q;
          commit_data = wdata;
          commit_strb = wstrb;
          state_d     = W_RESP;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          commit      = 1'b1;
          commit_addr = awaddr;
          commit_data = w_data_q;
          commit_strb = w_strb_q;
          state_d     = W_RESP;
        end
      end
      W_RESP: begin
        if (bvalid_q && bready) begin
          state_d = W_IDLE;
        end
      end
      default: state_d = W_IDLE;
    endcase

    // Readies and bvalid are registered images of the next state, so reset
    // leaves them low and they rise on the first edge after release.
    awready_d = (state_d == W_IDLE) || (state_d == W_HAVE_W);
    wready_d  = (state_d == W_IDLE) || (state_d == W_HAVE_AW);
    bvalid_d  = (state_d == W_RESP);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= W_IDLE;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite responder over a DEPTH x 8N-bit register file with flat export.
// Define AXI4_LITE_REG_SLAVE_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axi4_lite_reg_slave
  import axi4_lite_reg_slave_pkg::*;
#(
  parameter int A     = 8,
  parameter int N     = 4,
  parameter int DEPTH = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [A-1:0]         awaddr,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [8*N-1:0]       wdata,
  input  logic [N-1:0]         wstrb,
  input  logic                 wvalid,
  output logic                 wready,
  output logic [1:0]           bresp,
  output logic                 bvalid,
  input  logic                 bready,
  input  logic [A-1:0]         araddr,
  input  logic                 arvalid,
  output logic                 arready,
  output logic [8*N-1:0]       rdata,
  output logic [1:0]           rresp,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [DEPTH*8*N-1:0] regs
);

  localparam int          DW   = 8 * N;
  localparam int          IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NB   = N;
  localparam int unsigned DEP  = DEPTH;
  localparam int unsigned SPAN = DEPTH * N;

  logic                       commit;
  logic [A-1:0]               commit_addr;
  logic [DW-1:0]              commit_data;
  logic [N-1:0]               commit_strb;

  logic [DEPTH-1:0][DW-1:0]   regs_q, regs_d;
  logic [1:0]                 bresp_q, bresp_d;
  rd_state_e                  rd_state_q, rd_state_d;
  logic                       arready_q, arready_d;
  logic                       rvalid_q, rvalid_d;
  logic [DW-1:0]              rdata_q, rdata_d;
  logic [1:0]                 rresp_q, rresp_d;
  logic [IW-1:0]              wr_idx;
  logic [IW-1:0]              rd_idx;
  logic                       wr_oor;
  logic                       rd_oor;

  axi4_lite_wr_join #(
    .A (A),
    .N (N)
  ) u_wr_join (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .awaddr      (awaddr),
    .awvalid     (awvalid),
    .awready     (awready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wvalid      (wvalid),
    .wready      (wready),
    .bvalid      (bvalid),
    .bready      (bready),
    .commit      (commit),
    .commit_addr (commit_addr),
    .commit_data (commit_data),
    .commit_strb (commit_strb)
  );

  always_comb begin
    wr_idx = IW'(reg_index(32'(commit_addr), NB, DEP));
    rd_idx = IW'(reg_index(32'(araddr), NB, DEP));
`ifdef AXI4_LITE_REG_SLAVE_SLVERR_EN
    wr_oor = (32'(commit_addr) >= SPAN);
    rd_oor = (32'(araddr) >= SPAN);
`else
    wr_oor = 1'b0;
    rd_oor = 1'b0;
`endif
  end

  // Byte-strobed update of the addressed register on the commit edge.
  always_comb begin
    regs_d  = regs_q;
    bresp_d = bresp_q;
    if (commit) begin
      bresp_d = wr_oor ? RESP_SLVERR : RESP_OKAY;
      if (!wr_oor) begin
        for (int i = 0; i < N; i++) begin
          if (commit_strb[i]) begin
            regs_d[wr_idx][i*8 +: 8] = commit_data[i*8 +: 8];
          end
        end
      end
    end
  end

  // Reads sample regs_q, so a same-edge commit is seen by the next read only.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          rdata_d    = rd_oor ? '0 : regs_q[rd_idx];
          rresp_d    = rd_oor ? RESP_SLVERR : RESP_OKAY;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && rready) begin
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    arready_d = (rd_state_d == R_IDLE);
    rvalid_d  = (rd_state_d == R_DATA);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      regs_q     <= '0;
      bresp_q    <= RESP_OKAY;
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      regs_q     <= regs_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign regs    = regs_q;

endmodule
